// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3 vote
// over the last three synchronised samples (window ends on the decision cycle,
// so latency is the same as the single-sample build).
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  // state        | meaning
  // IDLE         | line idle, waiting for a low on the synchronised line
  // RX_START_BIT | counting to mid start bit to confirm it is not a glitch
  // RX_DATA_BITS | sampling 8 data bits at their centres
  // RX_STOP_BIT  | sampling the stop bit at its centre, raising DV or frame error
  // CLEANUP      | one cycle for the pulses to drop before looking for a new start
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RX_START_BIT = 3'd1,
    RX_DATA_BITS = 3'd2,
    RX_STOP_BIT  = 3'd3,
    CLEANUP      = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] CNT_HALF = 8'((CLKS_PER_BIT - 1) / 2);

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        active_q, active_d;
  logic        sample;

  // Two-flop synchroniser, preset to the idle-high line level
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1_q, rx_d2_q;

  // History of the synchronised line for the three-sample vote
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_d1_q <= 1'b1;
      rx_d2_q <= 1'b1;
    end else begin
      rx_d1_q <= rx_sync_q;
      rx_d2_q <= rx_d1_q;
    end
  end

  // 2-of-3 vote rejects a single-clock spike near the bit centre
  always_comb begin
    sample = (rx_sync_q & rx_d1_q) | (rx_sync_q & rx_d2_q) | (rx_d1_q & rx_d2_q);
  end
`else
  // Single sample taken on the decision cycle
  always_comb begin
    sample = rx_sync_q;
  end
`endif

  // State and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      data_q   <= 8'h00;
      byte_q   <= 8'h00;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) state_d = RX_START_BIT;
      end
      RX_START_BIT: begin
        if (cnt_q == CNT_HALF) state_d = sample ? IDLE : RX_DATA_BITS;
      end
      RX_DATA_BITS: begin
        if (cnt_q == CNT_LAST && idx_q == 3'd7) state_d = RX_STOP_BIT;
      end
      RX_STOP_BIT: begin
        if (cnt_q == CNT_LAST) state_d = CLEANUP;
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, data capture and registered output pulses
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    data_d = data_q;
    byte_d = byte_q;
    dv_d   = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
      end
      RX_START_BIT: begin
        cnt_d = (cnt_q == CNT_HALF) ? 8'd0 : cnt_q + 8'd1;
      end
      RX_DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = 8'd0;
          data_d[idx_q] = sample;
          idx_d         = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RX_STOP_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          if (sample) begin
            byte_d = data_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
      end
    endcase
    active_d = (state_d == RX_START_BIT) || (state_d == RX_DATA_BITS) ||
               (state_d == RX_STOP_BIT);
  end

  // Output drive
  always_comb begin
    o_RX_Byte      = byte_q;
    o_RX_DV        = dv_q;
    o_RX_Frame_Err = err_q;
    o_RX_Active    = active_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       line;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       rx_err;
  logic       rx_act;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int dv_total = 0;
  int err_total = 0;
  int act_total = 0;
  int both_total = 0;
  logic [7:0] dv_log [0:63];
  int         dv_cyc [0:63];

  int t0;
  int dv_base, err_base, act_base;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_RX_Serial    (line),
    .o_RX_Byte      (rx_byte),
    .o_RX_DV        (rx_dv),
    .o_RX_Frame_Err (rx_err),
    .o_RX_Active    (rx_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_dv) begin
        dv_log[dv_total[5:0]] <= rx_byte;
        dv_cyc[dv_total[5:0]] <= cyc;
        dv_total <= dv_total + 1;
      end
      if (rx_err) err_total <= err_total + 1;
      if (rx_act) act_total <= act_total + 1;
      if (rx_dv && rx_err) both_total <= both_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period; optional one-clock inversion at the receiver's sample point
  task automatic send_bit(input logic b, input logic spike);
    for (int c = 0; c < CPB; c++) begin
      line = (spike && c == 8) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic spike);
    t0 = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], spike);
    send_bit(stop_v, 1'b0);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap;
    dv_base  = dv_total;
    err_base = err_total;
    act_base = act_total;
  endtask

  initial begin
    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_byte", rx_byte, 8'h00);
    check("reset_dv", rx_dv, 1'b0);
    check("reset_err", rx_err, 1'b0);
    check("reset_active", rx_act, 1'b0);
    rst = 1'b0;
    idle(10);

    // 1: single frame, latency window
    snap();
    send_byte(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("t1_dv_count", dv_total - dv_base, 1);
    check("t1_byte", dv_log[dv_base[5:0]], 8'hA5);
    check("t1_out_byte", rx_byte, 8'hA5);
    check("t1_no_err", err_total - err_base, 0);
    check("t1_latency_window",
          ((dv_cyc[dv_base[5:0]] - t0) >= 154) && ((dv_cyc[dv_base[5:0]] - t0) <= 155), 1'b1);

    // 2: back-to-back frames, no idle gap
    snap();
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("t2_dv_count", dv_total - dv_base, 3);
    check("t2_byte0", dv_log[dv_base[5:0]], 8'h00);
    check("t2_byte1", dv_log[6'(dv_base + 1)], 8'hFF);
    check("t2_byte2", dv_log[6'(dv_base + 2)], 8'h3C);
    check("t2_no_err", err_total - err_base, 0);

    // 3: bad stop bit
    snap();
    send_byte(8'h55, 1'b0, 1'b0);
    idle(40);
    check("t3_err_pulse", err_total - err_base, 1);
    check("t3_no_dv", dv_total - dv_base, 0);
    check("t3_byte_kept", rx_byte, 8'h3C);

    // 4: short low glitch on idle line
    snap();
    line = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("t4_active_seen", act_total > act_base, 1'b1);
    check("t4_active_dropped", rx_act, 1'b0);
    check("t4_no_dv", dv_total - dv_base, 0);
    check("t4_no_err", err_total - err_base, 0);
    snap();
    send_byte(8'h81, 1'b1, 1'b0);
    idle(20);
    check("t4_dv_count", dv_total - dv_base, 1);
    check("t4_byte", dv_log[dv_base[5:0]], 8'h81);

    // 5: reset during bit 3
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    line = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_active_before_rst", rx_act, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_byte", rx_byte, 8'h00);
    check("t5_rst_dv", rx_dv, 1'b0);
    check("t5_rst_err", rx_err, 1'b0);
    check("t5_rst_active", rx_act, 1'b0);
    snap();
    @(negedge clk);
    idle(5);
    rst = 1'b0;
    idle(20);
    check("t5_no_pulse", (dv_total - dv_base) + (err_total - err_base), 0);
    snap();
    send_byte(8'h7E, 1'b1, 1'b0);
    idle(20);
    check("t5_dv_count", dv_total - dv_base, 1);
    check("t5_byte", dv_log[dv_base[5:0]], 8'h7E);

    // 6: one-clock spikes at each data bit centre
    snap();
    send_byte(8'hC3, 1'b1, 1'b1);
    idle(20);
    check("t6_dv_count", dv_total - dv_base, 1);
`ifdef UART_RX_MAJORITY_EN
    check("t6_byte_vote", dv_log[dv_base[5:0]], 8'hC3);
`else
    check("t6_byte_single", dv_log[dv_base[5:0]], 8'h3C);
`endif

    check("dv_err_exclusive", both_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
